// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution frame controller.
package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } ctrl_state_t;

   typedef logic signed [7:0] weight_t;

   localparam int NUM_TAPS = 9;

   // 3x3 Laplacian-style edge kernel, tap 4 is the centre (8), all others -1.
   localparam weight_t [NUM_TAPS-1:0] EDGE_KERNEL = {
      8'hFF, 8'hFF, 8'hFF,
      8'hFF, 8'h08, 8'hFF,
      8'hFF, 8'hFF, 8'hFF
   };

endpackage

// File: rtl/cnn_weight_regs.sv
// Kernel tap register file; resets to the edge kernel, out-of-range taps are dropped.
module cnn_weight_regs
   import cnn_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [3:0]               addr,
   input  weight_t                  wdata,
   output weight_t [NUM_TAPS-1:0]   weights
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weights <= EDGE_KERNEL;
      end else if (we && (addr < 4'(NUM_TAPS))) begin
         weights[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame-level controller for a 3x3 convolution datapath: gates pixel input,
// counts results, detects frame end or drain timeout, and holds the kernel taps.
module conv_frame_ctrl
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int IMG_WIDTH     = 28,
   parameter int IMG_HEIGHT    = 28,
   parameter int DRAIN_TIMEOUT = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic                     cfg_we,
   input  logic [3:0]               cfg_addr,
   input  logic [7:0]               cfg_wdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic                     dp_in_valid,
   input  logic                     dp_out_valid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output weight_t [NUM_TAPS-1:0]   o_weights,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err
);

   localparam int TOTAL_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int EXP_OUTS  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
   localparam int CW        = $clog2(TOTAL_PIX + 1);

   // A valid 3x3 window needs at least three pixels in each direction.
   if (DATA_WIDTH < 1 || IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_cfg
      $error("conv_frame_ctrl: unsupported image geometry or pixel width");
   end

   ctrl_state_t   state;
   ctrl_state_t   state_nx;
   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] out_cnt_nx;
   logic [CW-1:0] drain_cnt;
   logic          start_ok;
   logic          in_frame;
   logic          count_out;
   logic          outs_complete;
   logic          timeout;
   logic          err_set;
   logic          weight_we;

   assign start_ok      = (state == IDLE) && i_start;
   assign in_frame      = (state == RUN) || (state == DRAIN);
   assign s_axis_tready = (state == RUN) && (in_cnt < CW'(TOTAL_PIX));
   assign dp_in_valid   = s_axis_tvalid && s_axis_tready;
   assign m_axis_tlast  = dp_out_valid && in_frame && (out_cnt == CW'(EXP_OUTS - 1));

   // Surplus results are flagged as errors but never counted, so out_cnt cannot wrap.
   assign count_out     = dp_out_valid && in_frame && (out_cnt < CW'(EXP_OUTS));
   assign out_cnt_nx    = out_cnt + CW'(count_out);
   assign outs_complete = out_cnt_nx >= CW'(EXP_OUTS);
   assign timeout       = (state == DRAIN) && !outs_complete
                        && (drain_cnt == CW'(DRAIN_TIMEOUT - 1));
   assign err_set       = timeout
                        || (dp_out_valid && ((state == IDLE) || (out_cnt >= CW'(EXP_OUTS))))
                        || (dp_out_valid && !m_axis_tready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      o_busy   = 1'b1;
      o_done   = 1'b0;
      case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_nx = RUN;
         end
         RUN: begin
            if (dp_in_valid && (in_cnt == CW'(TOTAL_PIX - 1))) state_nx = DRAIN;
         end
         DRAIN: begin
            if (outs_complete || timeout) state_nx = DONE;
         end
         DONE: begin
            o_done   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt    <= '0;
         out_cnt   <= '0;
         drain_cnt <= '0;
      end else if (start_ok) begin
         in_cnt    <= '0;
         out_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         if (dp_in_valid)     in_cnt    <= in_cnt + 1'b1;
         if (count_out)       out_cnt   <= out_cnt_nx;
         if (state == DRAIN)  drain_cnt <= drain_cnt + 1'b1;
      end
   end

   // A fresh start wins over a stray result arriving in the same IDLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_err <= 1'b0;
      end else if (start_ok) begin
         o_err <= 1'b0;
      end else if (err_set) begin
         o_err <= 1'b1;
      end
   end

   assign weight_we = cfg_we && (state == IDLE);

   cnn_weight_regs u_weights (
      .clk     (clk),
      .rst     (rst),
      .we      (weight_we),
      .addr    (cfg_addr),
      .wdata   (weight_t'(cfg_wdata)),
      .weights (o_weights)
   );

endmodule
